// File: rtl/ycr_timer_mc_if.sv
// dmem bus between the core (master) and the multi-channel machine timer (slave).
// Handshake: a request is accepted in cycle T when dmem_req=1 and dmem_req_ack=0; dmem_req_ack
// pulses in T+1, and dmem_resp carries RDY_OK/RDY_ER for exactly one cycle in T+2 (NOTRDY otherwise).
interface ycr_timer_mc_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              dmem_req;
  logic              dmem_cmd;
  logic [1:0]        dmem_width;
  logic [AWIDTH-1:0] dmem_addr;
  logic [DWIDTH-1:0] dmem_wdata;
  logic              dmem_req_ack;
  logic [DWIDTH-1:0] dmem_rdata;
  logic [1:0]        dmem_resp;

  modport master (
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_req_ack, dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_req_ack, dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/ycr_timer_mc.sv
// Shared 64-bit mtime with prescaler and optional RTC tick source, plus NUM_CH
// 64-bit compare channels with sticky pending, IRQ enable and periodic auto-reload.
module ycr_timer_mc #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 10,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rtc_clk,
  ycr_timer_mc_if.slave     dmem,
  output logic [63:0]       timer_val,
  output logic [NUM_CH-1:0] timer_irq
);

  localparam logic [7:0] LP_LIMIT = 8'(16 + 16 * NUM_CH);
  localparam logic [1:0] LP_RESP_NOTRDY = 2'b00;
  localparam logic [1:0] LP_RESP_OK     = 2'b01;
  localparam logic [1:0] LP_RESP_ER     = 2'b10;

  // Bus capture and response registers
  logic        r_ack;
  logic        r_cmd;
  logic [1:0]  r_width;
  logic [6:0]  r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_resp;
  logic [31:0] r_rdata;

  // Global timer state
  logic             r_en;
  logic             r_clksrc;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic [63:0]      r_mtime;
  logic             r_rtc_tgl;
  logic [2:0]       r_rtc_sync;

  // Channel state
  logic [63:0]       r_cmp    [NUM_CH];
  logic [31:0]       r_period [NUM_CH];
  logic [NUM_CH-1:0] r_irq_en;
  logic [NUM_CH-1:0] r_periodic;
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_irq;

  logic              w_err;
  logic              w_wr;
  logic              w_wr_ctrl, w_wr_div, w_wr_mlo, w_wr_mhi;
  logic [NUM_CH-1:0] w_wr_cmplo, w_wr_cmphi, w_wr_period, w_wr_chctrl;
  logic [NUM_CH-1:0] w_match, w_auto;
  logic [31:0]       w_rdata;
  logic              w_rtc_pulse;
  logic              w_tick_en;
  logic              w_tick;
  logic              w_unused_addr;

  assign w_unused_addr = ^dmem.dmem_addr[AWIDTH-1:7];

  assign dmem.dmem_req_ack = r_ack;
  assign dmem.dmem_resp    = r_resp;
  assign dmem.dmem_rdata   = r_rdata;
  assign timer_val         = r_mtime;
  assign timer_irq         = r_irq;

  // Decode runs in T+1 on the captured request; an error suppresses every write strobe.
  always_comb begin
    w_err = (r_width != 2'b10) | (r_addr[1:0] != 2'b00) | ({1'b0, r_addr} >= LP_LIMIT);
    w_wr  = r_ack & r_cmd & ~w_err;
    w_wr_ctrl = w_wr & (r_addr[6:4] == 3'd0) & (r_addr[3:2] == 2'd0);
    w_wr_div  = w_wr & (r_addr[6:4] == 3'd0) & (r_addr[3:2] == 2'd1);
    w_wr_mlo  = w_wr & (r_addr[6:4] == 3'd0) & (r_addr[3:2] == 2'd2);
    w_wr_mhi  = w_wr & (r_addr[6:4] == 3'd0) & (r_addr[3:2] == 2'd3);
    w_wr_cmplo  = '0;
    w_wr_cmphi  = '0;
    w_wr_period = '0;
    w_wr_chctrl = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_wr && ({1'b0, r_addr[6:4]} == 4'(i + 1))) begin
        w_wr_cmplo[i]  = (r_addr[3:2] == 2'd0);
        w_wr_cmphi[i]  = (r_addr[3:2] == 2'd1);
        w_wr_period[i] = (r_addr[3:2] == 2'd2);
        w_wr_chctrl[i] = (r_addr[3:2] == 2'd3);
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (r_addr[6:4] == 3'd0) begin
      case (r_addr[3:2])
        2'd0:    w_rdata = {30'b0, r_clksrc, r_en};
        2'd1:    w_rdata = 32'(r_div);
        2'd2:    w_rdata = r_mtime[31:0];
        default: w_rdata = r_mtime[63:32];
      endcase
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ({1'b0, r_addr[6:4]} == 4'(i + 1)) begin
          case (r_addr[3:2])
            2'd0:    w_rdata = r_cmp[i][31:0];
            2'd1:    w_rdata = r_cmp[i][63:32];
            2'd2:    w_rdata = r_period[i];
            default: w_rdata = {29'b0, r_pend[i], r_periodic[i], r_irq_en[i]};
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_cmd   <= 1'b0;
      r_width <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_resp  <= LP_RESP_NOTRDY;
      r_rdata <= '0;
    end else begin
      r_ack <= dmem.dmem_req & ~r_ack;
      if (dmem.dmem_req && !r_ack) begin
        r_cmd   <= dmem.dmem_cmd;
        r_width <= dmem.dmem_width;
        r_addr  <= dmem.dmem_addr[6:0];
        r_wdata <= dmem.dmem_wdata;
      end
      r_resp  <= !r_ack ? LP_RESP_NOTRDY : (w_err ? LP_RESP_ER : LP_RESP_OK);
      r_rdata <= (r_ack && !r_cmd && !w_err) ? w_rdata : 32'h0;
    end
  end

  // RTC edges become level toggles so they cross into clk through a plain synchroniser.
  always_ff @(posedge rtc_clk or negedge rst_n) begin
    if (!rst_n)        r_rtc_tgl <= 1'b0;
    else if (r_clksrc) r_rtc_tgl <= ~r_rtc_tgl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rtc_sync <= 3'b000;
    else        r_rtc_sync <= {r_rtc_sync[1:0], r_rtc_tgl};
  end

  assign w_rtc_pulse = r_rtc_sync[2] ^ r_rtc_sync[1];
  assign w_tick_en   = r_en & (r_clksrc ? w_rtc_pulse : 1'b1);
  assign w_tick      = w_tick_en & (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en     <= 1'b1;
      r_clksrc <= 1'b0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_mtime  <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= r_wdata[0];
        r_clksrc <= r_wdata[1];
      end
      if (w_wr_div) begin
        r_div <= r_wdata[DIV_W-1:0];
        r_cnt <= r_wdata[DIV_W-1:0];
      end else if (w_tick_en) begin
        r_cnt <= (r_cnt == '0) ? r_div : r_cnt - 1'b1;
      end
      // A bus write to either half swallows a coincident tick.
      if (w_wr_mlo)      r_mtime[31:0]  <= r_wdata;
      else if (w_wr_mhi) r_mtime[63:32] <= r_wdata;
      else if (w_tick)   r_mtime        <= r_mtime + 64'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_match[i] = (r_mtime >= r_cmp[i]);
      w_auto[i]  = r_periodic[i] & (r_period[i] != 32'h0);
    end
  end

  // A one-shot compare rewrite drops pending so it re-arms against the new value;
  // otherwise a hardware set beats a same-cycle W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cmp[i]    <= '0;
        r_period[i] <= '0;
      end
      r_irq_en   <= '0;
      r_periodic <= '0;
      r_pend     <= '0;
      r_irq      <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_cmplo[i])                r_cmp[i][31:0]  <= r_wdata;
        else if (w_wr_cmphi[i])           r_cmp[i][63:32] <= r_wdata;
        else if (w_auto[i] && w_match[i]) r_cmp[i]        <= r_cmp[i] + {32'h0, r_period[i]};
        if (w_wr_period[i]) r_period[i] <= r_wdata;
        if (w_wr_chctrl[i]) begin
          r_irq_en[i]   <= r_wdata[0];
          r_periodic[i] <= r_wdata[1];
        end
        if (!w_auto[i] && (w_wr_cmplo[i] || w_wr_cmphi[i])) r_pend[i] <= 1'b0;
        else if (w_match[i])                                r_pend[i] <= 1'b1;
        else if (w_wr_chctrl[i] && r_wdata[2])              r_pend[i] <= 1'b0;
        r_irq[i] <= r_pend[i] & r_irq_en[i];
      end
    end
  end

endmodule

// File: tb/tb_ycr_timer_mc.sv
// Directed bench for ycr_timer_mc: bus handshake, prescaler, 64-bit carry/wrap,
// periodic and one-shot channels, error responses, RTC tick source, mid-transaction reset.
module tb_ycr_timer_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rtc_clk = 1'b0;
  logic [63:0] timer_val;
  logic [1:0]  timer_irq;

  int n_checks = 0;
  int n_pass   = 0;

  always #5  clk = ~clk;
  always #40 rtc_clk = ~rtc_clk;

  ycr_timer_mc_if #(.AWIDTH(32), .DWIDTH(32)) dmem ();

  ycr_timer_mc #(.NUM_CH(2), .DIV_W(10), .AWIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rtc_clk   (rtc_clk),
    .dmem      (dmem.slave),
    .timer_val (timer_val),
    .timer_irq (timer_irq)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One transaction: drive in T, sample ack in T+1, sample resp/rdata in T+2.
  task automatic bus(input logic cmd, input logic [1:0] width, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [1:0] resp,
                     output logic [31:0] rdata, output logic ack);
    @(negedge clk);
    dmem.dmem_req   = 1'b1;
    dmem.dmem_cmd   = cmd;
    dmem.dmem_width = width;
    dmem.dmem_addr  = addr;
    dmem.dmem_wdata = wdata;
    @(negedge clk);
    ack = dmem.dmem_req_ack;
    dmem.dmem_req = 1'b0;
    @(negedge clk);
    resp  = dmem.dmem_resp;
    rdata = dmem.dmem_rdata;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [1:0] resp;
    logic [31:0] rd_unused;
    logic ack;
    bus(1'b1, 2'b10, addr, data, resp, rd_unused, ack);
    check($sformatf("wr_resp_%0h", addr), 64'(resp), 64'h1);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    logic [1:0] resp;
    logic [31:0] data;
    logic ack;
    bus(1'b0, 2'b10, addr, 32'h0, resp, data, ack);
    check($sformatf("rd_resp_%0h", addr), 64'(resp), 64'h1);
    check($sformatf("rd_data_%0h", addr), 64'(data), 64'(exp));
  endtask

  task automatic err(input logic cmd, input logic [1:0] width, input logic [31:0] addr, input string tag);
    logic [1:0] resp;
    logic [31:0] data;
    logic ack;
    bus(cmd, width, addr, 32'h0000_0ABC, resp, data, ack);
    check({tag, "_resp"}, 64'(resp), 64'h2);
    check({tag, "_rdata"}, 64'(data), 64'h0);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    logic        ack;
    logic [63:0] v0, v1, dv;

    dmem.dmem_req   = 1'b0;
    dmem.dmem_cmd   = 1'b0;
    dmem.dmem_width = 2'b10;
    dmem.dmem_addr  = '0;
    dmem.dmem_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(dmem.dmem_req_ack), 64'h0);
    check("rst_resp", 64'(dmem.dmem_resp), 64'h0);
    check("rst_rdata", 64'(dmem.dmem_rdata), 64'h0);
    check("rst_irq", 64'(timer_irq), 64'h0);
    check("rst_mtime", timer_val, 64'h0);
    rst_n = 1'b1;

    bus(1'b0, 2'b10, 32'h00, 32'h0, resp, data, ack);
    check("first_ack", 64'(ack), 64'h1);
    check("first_resp", 64'(resp), 64'h1);
    check("first_ctrl", 64'(data), 64'h1);
    rd(32'h04, 32'h0);
    rd(32'h1C, 32'h4);  // cmp0=0 matches at once, so pending is already set

    // Prescaler: div=3 gives one tick every 4 clocks
    wr(32'h00, 32'h0);
    wr(32'h08, 32'h0);
    wr(32'h0C, 32'h0);
    wr(32'h04, 32'h3);
    wr(32'h00, 32'h1);
    repeat (40) @(negedge clk);
    check("div3_mtime", timer_val, 64'd10);

    // Low-to-high carry
    wr(32'h00, 32'h0);
    wr(32'h04, 32'h0);
    wr(32'h0C, 32'h0);
    wr(32'h08, 32'hFFFF_FFFF);
    check("carry_pre", timer_val, 64'h0000_0000_FFFF_FFFF);
    wr(32'h00, 32'h1);
    check("carry_hold", timer_val, 64'h0000_0000_FFFF_FFFF);
    @(negedge clk);
    check("carry_post", timer_val, 64'h0000_0001_0000_0000);

    // Full 64-bit wrap; the stopping write lets three more ticks through
    wr(32'h00, 32'h0);
    wr(32'h0C, 32'hFFFF_FFFF);
    wr(32'h08, 32'hFFFF_FFFF);
    wr(32'h00, 32'h1);
    @(negedge clk);
    check("wrap_mtime", timer_val, 64'h0);
    wr(32'h00, 32'h0);
    rd(32'h08, 32'd3);
    rd(32'h0C, 32'd0);

    // Channel 1 periodic, mtime stepped by hand
    wr(32'h08, 32'd0);
    wr(32'h20, 32'd100);
    wr(32'h24, 32'd0);
    wr(32'h28, 32'd50);
    wr(32'h2C, 32'h3);
    wr(32'h08, 32'd99);
    repeat (3) @(negedge clk);
    check("ch1_below", 64'(timer_irq), 64'h0);
    wr(32'h08, 32'd100);
    repeat (2) @(negedge clk);
    check("ch1_fire", 64'(timer_irq), 64'h2);
    rd(32'h20, 32'd150);
    rd(32'h2C, 32'h7);
    wr(32'h2C, 32'h7);
    repeat (2) @(negedge clk);
    check("ch1_w1c", 64'(timer_irq), 64'h0);
    wr(32'h08, 32'd150);
    repeat (2) @(negedge clk);
    check("ch1_refire", 64'(timer_irq), 64'h2);
    rd(32'h20, 32'd200);

    // Channel 0 one-shot
    wr(32'h2C, 32'h0);
    wr(32'h08, 32'd0);
    wr(32'h10, 32'd20);
    wr(32'h14, 32'd0);
    wr(32'h1C, 32'h1);
    repeat (2) @(negedge clk);
    check("ch0_armed", 64'(timer_irq), 64'h0);
    wr(32'h08, 32'd19);
    repeat (2) @(negedge clk);
    check("ch0_below", 64'(timer_irq), 64'h0);
    wr(32'h08, 32'd20);
    repeat (2) @(negedge clk);
    check("ch0_fire", 64'(timer_irq), 64'h1);
    repeat (5) @(negedge clk);
    check("ch0_held", 64'(timer_irq), 64'h1);
    wr(32'h10, 32'd1000);
    @(negedge clk);
    check("ch0_rearm", 64'(timer_irq), 64'h0);

    // Error responses leave state untouched
    err(1'b1, 2'b01, 32'h08, "err_half_wr");
    rd(32'h08, 32'd20);
    err(1'b0, 2'b01, 32'h00, "err_half_rd");
    err(1'b0, 2'b10, 32'h02, "err_misalign_rd");
    err(1'b1, 2'b10, 32'h06, "err_misalign_wr");
    rd(32'h04, 32'h0);
    err(1'b1, 2'b10, 32'h30, "err_range_wr");
    err(1'b0, 2'b10, 32'h30, "err_range_rd");

    // RTC source at clk/8
    wr(32'h08, 32'd0);
    wr(32'h00, 32'h3);
    repeat (16) @(negedge clk);
    v0 = timer_val;
    repeat (80) @(negedge clk);
    v1 = timer_val;
    dv = v1 - v0;
    if (dv < 64'd9 || dv > 64'd11) $display("rtc tick count over 80 clk: %0d", dv);
    check("rtc_rate", 64'(dv >= 64'd9 && dv <= 64'd11), 64'h1);

    // Reset while a transaction is in flight: no response follows
    @(negedge clk);
    dmem.dmem_req   = 1'b1;
    dmem.dmem_cmd   = 1'b0;
    dmem.dmem_width = 2'b10;
    dmem.dmem_addr  = 32'h00;
    @(negedge clk);
    dmem.dmem_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_resp", 64'(dmem.dmem_resp), 64'h0);
    check("midrst_mtime", timer_val, 64'h0);
    rst_n = 1'b1;
    rd(32'h00, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
